scoreboard_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 4-digit active-low 7-segment scoreboard display. Generates its own prescaled scan tick and sequences digit select with an inter-digit blanking interval to suppress ghosting. Captures a new BCD score only at frame boundaries through a valid/ready handshake, so a frame never tears. Sits between the scoreboard score logic and the board's anode/segment pins.

---
 rtl/scoreboard_scan_ctrl_if.sv | 22 ++
 rtl/scoreboard_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_scoreboard_scan_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_scan_ctrl_if.sv
// Score/display bundle between the score logic, the scan controller and the board pins.
// master = score source / board side, slave = scan controller.
interface scoreboard_scan_ctrl_if;
   logic        en;
   logic [15:0] score_in;
   logic        score_valid;
   logic        score_ready;
   logic        lz_blank;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        frame_done;

   modport master (
      output en, score_in, score_valid, lz_blank,
      input  score_ready, an, seg, frame_done
   );

   modport slave (
      input  en, score_in, score_valid, lz_blank,
      output score_ready, an, seg, frame_done
   );
endinterface

// File: rtl/scoreboard_scan_ctrl.sv
// Time-multiplexed scan of a 4-digit active-low 7-segment display with
// inter-digit blanking and frame-boundary score capture.
module scoreboard_scan_ctrl #(
   parameter int unsigned PRESCALE    = 50000,
   parameter int unsigned BLANK_TICKS = 1,
   parameter int unsigned SHOW_TICKS  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   scoreboard_scan_ctrl_if.slave bus
);

   localparam int unsigned PW   = $clog2(PRESCALE);
   localparam int unsigned TMAX = (BLANK_TICKS > SHOW_TICKS) ? BLANK_TICKS : SHOW_TICKS;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
   localparam logic [TW-1:0] B_LAST = TW'(BLANK_TICKS - 1);
   localparam logic [TW-1:0] S_LAST = TW'(SHOW_TICKS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, BLANK, SHOW} state_t;

   state_t      state, state_n;
   logic [1:0]  idx, idx_n;
   logic [PW-1:0] presc, presc_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic [15:0] shadow, shadow_n;
   logic [3:0]  an_q, an_n;
   logic [6:0]  seg_q, seg_n;
   logic        ready_q, ready_n;
   logic        fdone_q, fdone_n;
   logic        tick;
   logic [3:0]  zero_from;
   logic        blank_digit;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'b0111111;
      endcase
   endfunction

   // zero_from[i]: digit i and every higher digit are zero; digit0 is never blanked
   always_comb begin
      zero_from    = '0;
      zero_from[3] = (shadow[15:12] == 4'd0);
      zero_from[2] = zero_from[3] && (shadow[11:8] == 4'd0);
      zero_from[1] = zero_from[2] && (shadow[7:4] == 4'd0);
   end

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      presc_n  = '0;
      tcnt_n   = tcnt;
      shadow_n = shadow;
      fdone_n  = 1'b0;
      tick     = (presc == P_LAST);

      case (state)
         IDLE: if (bus.en) state_n = LOAD;
         LOAD: begin
            if (bus.score_valid) shadow_n = bus.score_in;
            state_n = BLANK;
         end
         BLANK: if (tick) begin
            if (tcnt == B_LAST) state_n = SHOW;
            else                tcnt_n  = tcnt + TW'(1);
         end
         SHOW: if (tick) begin
            if (tcnt == S_LAST) begin
               if (idx == 2'd3) begin
                  idx_n   = '0;
                  state_n = LOAD;
                  fdone_n = 1'b1;
               end else begin
                  idx_n   = idx + 2'd1;
                  state_n = BLANK;
               end
            end else begin
               tcnt_n = tcnt + TW'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      // A capture already granted in LOAD is still honoured when en drops there.
      if (state != IDLE && !bus.en) begin
         state_n = IDLE;
         idx_n   = '0;
         fdone_n = 1'b0;
      end

      if (state_n != state) tcnt_n = '0;
      if ((state == BLANK || state == SHOW) && (state_n == BLANK || state_n == SHOW))
         presc_n = tick ? '0 : presc + PW'(1);

      blank_digit = bus.lz_blank && zero_from[idx_n];
      an_n        = '1;
      seg_n       = '1;
      ready_n     = (state_n == LOAD);
      if (state_n == SHOW && !blank_digit) begin
         an_n[idx_n] = 1'b0;
         seg_n       = decode(shadow[{idx_n, 2'b00} +: 4]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         idx     <= '0;
         presc   <= '0;
         tcnt    <= '0;
         shadow  <= '0;
         an_q    <= '1;
         seg_q   <= '1;
         ready_q <= 1'b0;
         fdone_q <= 1'b0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         presc   <= presc_n;
         tcnt    <= tcnt_n;
         shadow  <= shadow_n;
         an_q    <= an_n;
         seg_q   <= seg_n;
         ready_q <= ready_n;
         fdone_q <= fdone_n;
      end
   end

   assign bus.an          = an_q;
   assign bus.seg         = seg_q;
   assign bus.score_ready = ready_q;
   assign bus.frame_done  = fdone_q;

endmodule

// File: tb/tb_scoreboard_scan_ctrl.sv
// Bench for scoreboard_scan_ctrl: expected display runs {an,seg,ready,frame_done,length}
// are queued as stimulus is issued; a monitor pops one per observed run.
module tb_scoreboard_scan_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scoreboard_scan_ctrl_if bus ();

   scoreboard_scan_ctrl #(
      .PRESCALE   (4),
      .BLANK_TICKS(1),
      .SHOW_TICKS (3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic [12:0] pat;
      int unsigned len;
   } run_t;

   localparam logic [12:0] BLANKP = {4'hF, 7'h7F, 2'b00};

   run_t        exp_q[$];
   int unsigned checks = 0;
   int unsigned fails  = 0;
   logic        mon_en = 1'b0;
   logic [12:0] acc_pat;
   int unsigned acc_len;
   bit          acc_skip;
   int unsigned rel;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: seg_of = 7'h40;  4'd1: seg_of = 7'h79;
         4'd2: seg_of = 7'h24;  4'd3: seg_of = 7'h30;
         4'd4: seg_of = 7'h19;  4'd5: seg_of = 7'h12;
         4'd6: seg_of = 7'h02;  4'd7: seg_of = 7'h78;
         4'd8: seg_of = 7'h00;  4'd9: seg_of = 7'h10;
         default: seg_of = 7'h3F;
      endcase
   endfunction

   function automatic logic [12:0] digit_pat(input logic [15:0] sh, input int unsigned d,
                                             input logic lz);
      logic [3:0]  a;
      logic [15:0] upper;
      upper = sh >> (4 * d);
      if (lz && d != 0 && upper == 16'h0) return BLANKP;
      a    = 4'hF;
      a[d] = 1'b0;
      return {a, seg_of(sh[4*d +: 4]), 2'b00};
   endfunction

   // Adjacent identical patterns merge into one run, as the monitor sees them.
   task automatic emit(input logic [12:0] p, input int unsigned n);
      run_t r;
      if (p == acc_pat) acc_len += n;
      else begin
         if (!acc_skip) begin
            r.pat = acc_pat;
            r.len = acc_len;
            exp_q.push_back(r);
         end
         acc_skip = 1'b0;
         acc_pat  = p;
         acc_len  = n;
      end
   endtask

   task automatic emit_frame(input logic [15:0] sh, input logic lz, input logic fd);
      emit({4'hF, 7'h7F, 1'b1, fd}, 1);
      for (int unsigned d = 0; d < 4; d++) begin
         emit(BLANKP, 4);
         emit(digit_pat(sh, d, lz), 12);
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic step_to(input int unsigned k);
      while (rel < k) begin
         @(negedge clk);
         rel++;
      end
   endtask

   task automatic check_blank(input string tag);
      check({tag, " an"}, 32'(bus.an), 32'hF);
      check({tag, " seg"}, 32'(bus.seg), 32'h7F);
      check({tag, " score_ready"}, 32'(bus.score_ready), 32'h0);
      check({tag, " frame_done"}, 32'(bus.frame_done), 32'h0);
   endtask

   initial begin : monitor
      logic [12:0] prev, cur;
      int unsigned len;
      bit          first, active;
      run_t        r;
      active = 1'b0;
      first  = 1'b1;
      len    = 0;
      prev   = '0;
      forever begin
         @(posedge clk);
         #1;
         cur = {bus.an, bus.seg, bus.score_ready, bus.frame_done};
         if (!mon_en) active = 1'b0;
         else if (!active) begin
            active = 1'b1;
            first  = 1'b1;
            prev   = cur;
            len    = 1;
         end else if (cur == prev) len++;
         else begin
            if (!first) begin
               checks++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL run: unexpected an=%b seg=%b rdy=%b fd=%b len=%0d",
                           prev[12:9], prev[8:2], prev[1], prev[0], len);
               end else begin
                  r = exp_q.pop_front();
                  if (r.pat !== prev || r.len != len) begin
                     fails++;
                     $display("FAIL run: got an=%b seg=%b rdy=%b fd=%b len=%0d, expected an=%b seg=%b rdy=%b fd=%b len=%0d",
                              prev[12:9], prev[8:2], prev[1], prev[0], len,
                              r.pat[12:9], r.pat[8:2], r.pat[1], r.pat[0], r.len);
                  end
               end
            end
            first = 1'b0;
            prev  = cur;
            len   = 1;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : driver
      acc_pat  = BLANKP;
      acc_len  = 0;
      acc_skip = 1'b1;
      rel      = 0;
      rst      = 1'b1;
      bus.en          = 1'b1;
      bus.score_in    = 16'h1234;
      bus.score_valid = 1'b1;
      bus.lz_blank    = 1'b0;
      #1 rst = 1'b0;
      #1 check_blank("reset_t0");
      repeat (3) @(negedge clk);
      check_blank("reset_held");
      bus.en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_blank("idle_en0");
      mon_en = 1'b1;
      @(negedge clk);

      rel = 0;
      bus.en = 1'b1;
      emit_frame(16'h1234, 1'b0, 1'b0);
      step_to(25);
      bus.score_in = 16'h0005;
      bus.lz_blank = 1'b1;
      emit_frame(16'h0005, 1'b1, 1'b1);
      step_to(80);
      bus.score_in = 16'h0000;
      emit_frame(16'h0000, 1'b1, 1'b1);
      step_to(140);
      bus.score_in = 16'h10A0;
      emit_frame(16'h10A0, 1'b1, 1'b1);
      step_to(210);
      bus.score_in = 16'h0905;
      emit_frame(16'h0905, 1'b0, 1'b1);
      step_to(255);
      bus.lz_blank = 1'b0;
      step_to(270);
      bus.score_in = 16'h9876;
      emit({4'hF, 7'h7F, 2'b11}, 1);
      emit(BLANKP, 4);
      emit(digit_pat(16'h9876, 0, 1'b0), 12);
      emit(BLANKP, 4);
      emit(digit_pat(16'h9876, 1, 1'b0), 12);
      emit(BLANKP, 4);
      emit(digit_pat(16'h9876, 2, 1'b0), 4);
      emit(BLANKP, 6);
      step_to(366);
      bus.en          = 1'b0;
      bus.score_valid = 1'b0;
      step_to(372);
      bus.en = 1'b1;
      emit({4'hF, 7'h7F, 2'b10}, 1);
      emit(BLANKP, 4);
      emit(digit_pat(16'h9876, 0, 1'b0), 12);
      emit(BLANKP, 4);
      emit(digit_pat(16'h9876, 1, 1'b0), 1);
      step_to(396);
      check("digit1_shown_before_reset", 32'(bus.an), 32'hD);
      mon_en = 1'b0;
      #2 rst = 1'b0;
      #1 check_blank("reset_midshow");
      check("queue_drained", exp_q.size(), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
